frequency_generator: RTL and testbench
======================================

Name: frequency_generator

Overview:
- Generates a square-wave output, Frequency_EvtOut, phase-aligned to the local ClockTime. This is the transmit-side counterpart of the frequency counter: it produces a signal where the counter measures one.
- The half-period in nanoseconds is programmed over an AXI4-Lite slave (16-bit address space).
- Every output cycle restarts at a full-second boundary, so the rising edge coincides with the PPS.
- Sits beside the frequency counter in the Time-Card design and reuses the same ClockTime bus.

Parameters:
- ClockPeriod_Gen, 20, SysClk period in ns; sets the comparison tolerance and the minimum half-period.
- OutputPolarity_Gen, "true", "true" = active-high output, "false" = inverted output (idle level included).

Ports:
- SysClk_ClkIn  in  1  system clock, single clock domain.
- SysRstN_RstIn  in  1  reset, asynchronous, active-low.
- ClockTime_Second_DatIn  in  32  local time, seconds.
- ClockTime_Nanosecond_DatIn  in  32  local time, ns (0..999_999_999).
- ClockTime_TimeJump_DatIn  in  1  time step occurred this cycle.
- ClockTime_ValIn  in  1  time valid.
- Frequency_EvtOut  out  1  generated square wave.
- AxiWriteAddrValid_ValIn / AxiWriteAddrReady_RdyOut / AxiWriteAddrAddress_AdrIn[15:0] / AxiWriteAddrProt_DatIn[2:0]  AXI AW channel.
- AxiWriteDataValid_ValIn / AxiWriteDataReady_RdyOut / AxiWriteDataData_DatIn[31:0] / AxiWriteDataStrobe_DatIn[3:0]  AXI W channel.
- AxiWriteRespValid_ValOut / AxiWriteRespReady_RdyIn / AxiWriteRespResponse_DatOut[1:0]  AXI B channel.
- AxiReadAddrValid_ValIn / AxiReadAddrReady_RdyOut / AxiReadAddrAddress_AdrIn[15:0] / AxiReadAddrProt_DatIn[2:0]  AXI AR channel.
- AxiReadDataValid_ValOut / AxiReadDataReady_RdyIn / AxiReadDataResponse_DatOut[1:0] / AxiReadDataData_DatOut[31:0]  AXI R channel.

Behaviour:
- Reset values:
  - All AXI valid/ready outputs 0, responses 00, RDATA 0.
  - Frequency_EvtOut = inactive level (0 if polarity "true", 1 if "false").
  - All registers 0; FSM in Idle.
- Register map (32-bit, word-aligned):
  - 0x0000 Control: bit0 Enable.
  - 0x0004 Status: bit0 Error, sticky, write-1-to-clear.
  - 0x0008 HalfPeriod_Ns.
  - 0x000C Version, constant 0x0001_0000.
  - Unmapped addresses read 0; writes to them are ignored. RRESP and BRESP are always OKAY (00). Strobes and Prot are ignored (full-word writes only).
- AXI write handshake:
  - Fires only when AWVALID and WVALID are both high and no response is pending.
  - AWREADY and WREADY pulse together for 1 cycle; the register updates on that same edge.
  - BVALID rises the next cycle and is held until BREADY.
- AXI read handshake:
  - ARREADY pulses 1 cycle; RVALID and RDATA follow one cycle later and are held until RREADY.
  - Only one transaction is outstanding per direction. Reads and writes are independent.
- FSM Idle:
  - Output inactive.
  - Leaves when Enable=1 and ClockTime_ValIn=1.
  - If HalfPeriod_Ns < 2*ClockPeriod_Gen or > 500_000_000: set Error, clear Enable, stay in Idle.
  - Otherwise go to WaitSecond.
- FSM WaitSecond:
  - Latch LastSecond, output inactive.
  - When Second ≠ LastSecond: output active, NextToggle = HalfPeriod, go to Running.
- FSM Running, every cycle with ValIn=1:
  - Second ≠ LastSecond (new second): output active, NextToggle = HalfPeriod, LastSecond = Second. This branch wins over a simultaneous toggle match.
  - Else if Nanosecond >= NextToggle and NextToggle < 1_000_000_000: invert output, NextToggle += HalfPeriod.
  - NextToggle is 31 bits; the sum cannot overflow because HalfPeriod ≤ 5e8 and the addition is gated by NextToggle < 1e9.
  - Result: the last partial cycle before a second boundary is truncated when 1e9 is not a multiple of 2*HalfPeriod.
- Output timing: the output is registered, so edges appear 1 cycle after the matching ClockTime sample. Edge jitter is ≤ ClockPeriod_Gen.
- Fault conditions:
  - TimeJump=1 or ValIn=0 while in WaitSecond or Running: set Error, output inactive, go to WaitSecond.
  - The FSM re-arms automatically on the next valid second change.
- Software control:
  - Enable cleared in any state: next cycle goes to Idle with output inactive.
  - Writing HalfPeriod while running takes effect at the next second boundary. The shadow value is sampled on entering Running and at each new second.
- Async reset asserted mid-operation: everything returns immediately to reset values.

Decomposition:
- Shared package frequency_generator_pkg:
  - Register offsets, Version constant, HalfPeriod min/max.
  - FSM state enum {Idle, WaitSecond, Running}.
  - Constant 1_000_000_000.
- One sub-module, axi_lite_reg_slave: AXI4-Lite handshakes and the register file (Control, Status W1C, HalfPeriod, Version).
- Generator FSM and output register live in the top level.

Test Plan:
- Reset: hold SysRstN low with random AXI inputs -> all ready/valid outputs 0 and Frequency_EvtOut 0. Read 0x000C -> 0x0001_0000, RRESP 00.
- HalfPeriod=250_000_000, Enable=1, clean time at 20 ns steps -> first rising edge 1 cycle after the second increments; falls at ns 250_000_000(+1 cycle); rises at 500_000_000; exactly 2 cycles per second.
- HalfPeriod=300_000_000 -> toggles at 300M, 600M, 900M; output forced active at the second wrap (truncated cycle); Error stays 0.
- HalfPeriod=30 with ClockPeriod_Gen=20 -> Enable self-clears, Status=0x1, output stays 0. Write 0x1 to 0x0004 -> Status reads 0.
- Running, pulse TimeJump for 1 cycle -> output inactive the next cycle, Error=1, restart at the next second change.
- AW asserted 5 cycles before W -> no READY until both are valid, then a single BVALID. BREADY held low 10 cycles -> BVALID stays 1 with no second write accepted.

Source files
------------

// File: rtl/frequency_generator_pkg.sv
// Shared definitions for the frequency generator: register offsets, constants,
// generator FSM states and the half-period range check.
package frequency_generator_pkg;

  localparam logic [15:0] addrControl    = 16'h0000;
  localparam logic [15:0] addrStatus     = 16'h0004;
  localparam logic [15:0] addrHalfPeriod = 16'h0008;
  localparam logic [15:0] addrVersion    = 16'h000C;

  localparam logic [31:0] versionValue   = 32'h0001_0000;
  localparam logic [31:0] halfPeriodMax  = 32'd500_000_000;
  localparam logic [31:0] nsPerSecond    = 32'd1_000_000_000;

  typedef enum logic [1:0] {
    Idle       = 2'd0,
    WaitSecond = 2'd1,
    Running    = 2'd2
  } genState_t;

  // A half period is usable when it spans at least two clock periods and a full
  // output cycle still fits in one second.
  function automatic logic halfPeriodValid(input logic [31:0] halfPeriod,
                                           input logic [31:0] halfPeriodMin);
    return (halfPeriod >= halfPeriodMin) && (halfPeriod <= halfPeriodMax);
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave holding the generator registers.
//   clk/rstN        : clock, asynchronous active-low reset
//   aw*/w*/b*       : write address, write data and write response channels
//   ar*/r*          : read address and read data channels
//   setError        : pulse from the generator, sets the sticky Error bit
//   clearEnable     : pulse from the generator, clears Enable
//   enable          : Control.Enable
//   halfPeriod      : HalfPeriod_Ns register
module axi_lite_reg_slave
  import frequency_generator_pkg::*;
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        awValid,
  output logic        awReady,
  input  logic [15:0] awAddr,
  input  logic        wValid,
  output logic        wReady,
  input  logic [31:0] wData,
  output logic        bValid,
  input  logic        bReady,
  output logic [1:0]  bResp,
  input  logic        arValid,
  output logic        arReady,
  input  logic [15:0] arAddr,
  output logic        rValid,
  input  logic        rReady,
  output logic [1:0]  rResp,
  output logic [31:0] rData,
  input  logic        setError,
  input  logic        clearEnable,
  output logic        enable,
  output logic [31:0] halfPeriod
);

  logic        error;
  logic        wrEn;
  logic        rdEn;
  logic        statusClear;
  logic [31:0] readMux;

  // AWREADY and WREADY are one shared pulse; the write lands on the edge
  // where that pulse is high.
  assign wReady      = awReady;
  assign wrEn        = awReady && awValid && wValid;
  assign rdEn        = arReady && arValid;
  assign statusClear = wrEn && (awAddr == addrStatus) && wData[0];
  assign bResp       = 2'b00;
  assign rResp       = 2'b00;

  always_comb begin
    readMux = '0;
    case (arAddr)
      addrControl:    readMux = {31'd0, enable};
      addrStatus:     readMux = {31'd0, error};
      addrHalfPeriod: readMux = halfPeriod;
      addrVersion:    readMux = versionValue;
      default:        readMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      awReady    <= 1'b0;
      bValid     <= 1'b0;
      arReady    <= 1'b0;
      rValid     <= 1'b0;
      rData      <= '0;
      enable     <= 1'b0;
      error      <= 1'b0;
      halfPeriod <= '0;
    end else begin
      // A pending response blocks the next write until it is accepted.
      awReady <= awValid && wValid && !awReady && !bValid;
      arReady <= arValid && !arReady && !rValid;

      if (wrEn) begin
        bValid <= 1'b1;
      end else if (bValid && bReady) begin
        bValid <= 1'b0;
      end

      if (rdEn) begin
        rValid <= 1'b1;
        rData  <= readMux;
      end else if (rValid && rReady) begin
        rValid <= 1'b0;
        rData  <= '0;
      end

      // A hardware error in the same cycle as a W1C keeps the bit set.
      error <= setError || (error && !statusClear);

      if (wrEn && (awAddr == addrControl)) begin
        enable <= wData[0];
      end else if (clearEnable) begin
        enable <= 1'b0;
      end

      if (wrEn && (awAddr == addrHalfPeriod)) begin
        halfPeriod <= wData;
      end
    end
  end

endmodule

// File: rtl/frequency_generator.sv
// Square-wave generator phase-aligned to ClockTime: every second starts with an
// active edge, then the output toggles each HalfPeriod_Ns until the second ends.
//   SysClk_ClkIn / SysRstN_RstIn : clock, asynchronous active-low reset
//   ClockTime_*                  : local time bus (seconds, ns, jump flag, valid)
//   Frequency_EvtOut             : generated square wave
//   Axi*                         : AXI4-Lite register interface (Prot/Strobe ignored)
module frequency_generator
  import frequency_generator_pkg::*;
#(
  parameter int    ClockPeriod_Gen    = 20,
  parameter string OutputPolarity_Gen = "true"
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRstN_RstIn,
  input  logic [31:0] ClockTime_Second_DatIn,
  input  logic [31:0] ClockTime_Nanosecond_DatIn,
  input  logic        ClockTime_TimeJump_DatIn,
  input  logic        ClockTime_ValIn,
  output logic        Frequency_EvtOut,
  input  logic        AxiWriteAddrValid_ValIn,
  output logic        AxiWriteAddrReady_RdyOut,
  input  logic [15:0] AxiWriteAddrAddress_AdrIn,
  input  logic [2:0]  AxiWriteAddrProt_DatIn,
  input  logic        AxiWriteDataValid_ValIn,
  output logic        AxiWriteDataReady_RdyOut,
  input  logic [31:0] AxiWriteDataData_DatIn,
  input  logic [3:0]  AxiWriteDataStrobe_DatIn,
  output logic        AxiWriteRespValid_ValOut,
  input  logic        AxiWriteRespReady_RdyIn,
  output logic [1:0]  AxiWriteRespResponse_DatOut,
  input  logic        AxiReadAddrValid_ValIn,
  output logic        AxiReadAddrReady_RdyOut,
  input  logic [15:0] AxiReadAddrAddress_AdrIn,
  input  logic [2:0]  AxiReadAddrProt_DatIn,
  output logic        AxiReadDataValid_ValOut,
  input  logic        AxiReadDataReady_RdyIn,
  output logic [1:0]  AxiReadDataResponse_DatOut,
  output logic [31:0] AxiReadDataData_DatOut
);

  localparam bit          activeHigh    = (OutputPolarity_Gen == "true");
  localparam logic [31:0] halfPeriodMin = 32'(2 * ClockPeriod_Gen);

  logic        enable;
  logic [31:0] halfPeriod;
  logic        setError;
  logic        clearEnable;

  genState_t   state, stateNext;
  logic        activeReg, activeNext;
  logic [31:0] lastSecond, lastSecondNext;
  logic [30:0] nextToggle, nextToggleNext;
  logic [30:0] halfActive, halfActiveNext;

  logic        fault;
  logic        newSecond;
  logic        toggleDue;

  axi_lite_reg_slave regs (
    .clk         (SysClk_ClkIn),
    .rstN        (SysRstN_RstIn),
    .awValid     (AxiWriteAddrValid_ValIn),
    .awReady     (AxiWriteAddrReady_RdyOut),
    .awAddr      (AxiWriteAddrAddress_AdrIn),
    .wValid      (AxiWriteDataValid_ValIn),
    .wReady      (AxiWriteDataReady_RdyOut),
    .wData       (AxiWriteDataData_DatIn),
    .bValid      (AxiWriteRespValid_ValOut),
    .bReady      (AxiWriteRespReady_RdyIn),
    .bResp       (AxiWriteRespResponse_DatOut),
    .arValid     (AxiReadAddrValid_ValIn),
    .arReady     (AxiReadAddrReady_RdyOut),
    .arAddr      (AxiReadAddrAddress_AdrIn),
    .rValid      (AxiReadDataValid_ValOut),
    .rReady      (AxiReadDataReady_RdyIn),
    .rResp       (AxiReadDataResponse_DatOut),
    .rData       (AxiReadDataData_DatOut),
    .setError    (setError),
    .clearEnable (clearEnable),
    .enable      (enable),
    .halfPeriod  (halfPeriod)
  );

  assign fault     = ClockTime_TimeJump_DatIn || !ClockTime_ValIn;
  assign newSecond = (ClockTime_Second_DatIn != lastSecond);
  // Toggles stop once the schedule passes the end of the second, which also
  // keeps the 31-bit accumulator from overflowing.
  assign toggleDue = (ClockTime_Nanosecond_DatIn >= {1'b0, nextToggle}) &&
                     ({1'b0, nextToggle} < nsPerSecond);

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      state <= Idle;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (!enable) begin
      stateNext = Idle;
    end else begin
      case (state)
        Idle:
          if (ClockTime_ValIn && halfPeriodValid(halfPeriod, halfPeriodMin)) begin
            stateNext = WaitSecond;
          end
        WaitSecond:
          if (!fault && newSecond) begin
            stateNext = Running;
          end
        Running:
          if (fault) begin
            stateNext = WaitSecond;
          end
        default: stateNext = Idle;
      endcase
    end
  end

  always_comb begin
    activeNext     = activeReg;
    lastSecondNext = lastSecond;
    nextToggleNext = nextToggle;
    halfActiveNext = halfActive;
    setError       = 1'b0;
    clearEnable    = 1'b0;
    if (!enable) begin
      activeNext = 1'b0;
    end else begin
      case (state)
        Idle: begin
          activeNext     = 1'b0;
          // Tracked while idle so that WaitSecond starts from the entry second.
          lastSecondNext = ClockTime_Second_DatIn;
          if (ClockTime_ValIn && !halfPeriodValid(halfPeriod, halfPeriodMin)) begin
            setError    = 1'b1;
            clearEnable = 1'b1;
          end
        end
        WaitSecond, Running: begin
          if (fault) begin
            setError       = 1'b1;
            activeNext     = 1'b0;
            lastSecondNext = ClockTime_Second_DatIn;
          end else if (newSecond) begin
            // Second boundary wins over a coincident toggle; new half period
            // takes effect only here.
            activeNext     = 1'b1;
            halfActiveNext = halfPeriod[30:0];
            nextToggleNext = halfPeriod[30:0];
            lastSecondNext = ClockTime_Second_DatIn;
          end else if (state == WaitSecond) begin
            activeNext = 1'b0;
          end else if (toggleDue) begin
            activeNext     = !activeReg;
            nextToggleNext = nextToggle + halfActive;
          end
        end
        default: activeNext = 1'b0;
      endcase
    end
  end

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      activeReg  <= 1'b0;
      lastSecond <= '0;
      nextToggle <= '0;
      halfActive <= '0;
    end else begin
      activeReg  <= activeNext;
      lastSecond <= lastSecondNext;
      nextToggle <= nextToggleNext;
      halfActive <= halfActiveNext;
    end
  end

  assign Frequency_EvtOut = activeHigh ? activeReg : !activeReg;

endmodule

// File: tb/tb_frequency_generator.sv
`timescale 1ns/1ps
module tb_frequency_generator;

  localparam logic [31:0] NS1E9 = 32'd1_000_000_000;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] timeSec, timeNs, timeStep;
  logic        timeJump, timeVal;
  logic        evt;
  logic        awValid, awReady, wValid, wReady, bValid, bReady;
  logic        arValid, arReady, rValid, rReady;
  logic [15:0] awAddr, arAddr;
  logic [2:0]  awProt, arProt;
  logic [31:0] wData, rData;
  logic [3:0]  wStrb;
  logic [1:0]  bResp, rResp;

  always #10 clk = ~clk;

  frequency_generator #(.ClockPeriod_Gen(20), .OutputPolarity_Gen("true")) dut (
    .SysClk_ClkIn                (clk),
    .SysRstN_RstIn               (rstN),
    .ClockTime_Second_DatIn      (timeSec),
    .ClockTime_Nanosecond_DatIn  (timeNs),
    .ClockTime_TimeJump_DatIn    (timeJump),
    .ClockTime_ValIn             (timeVal),
    .Frequency_EvtOut            (evt),
    .AxiWriteAddrValid_ValIn     (awValid),
    .AxiWriteAddrReady_RdyOut    (awReady),
    .AxiWriteAddrAddress_AdrIn   (awAddr),
    .AxiWriteAddrProt_DatIn      (awProt),
    .AxiWriteDataValid_ValIn     (wValid),
    .AxiWriteDataReady_RdyOut    (wReady),
    .AxiWriteDataData_DatIn      (wData),
    .AxiWriteDataStrobe_DatIn    (wStrb),
    .AxiWriteRespValid_ValOut    (bValid),
    .AxiWriteRespReady_RdyIn     (bReady),
    .AxiWriteRespResponse_DatOut (bResp),
    .AxiReadAddrValid_ValIn      (arValid),
    .AxiReadAddrReady_RdyOut     (arReady),
    .AxiReadAddrAddress_AdrIn    (arAddr),
    .AxiReadAddrProt_DatIn       (arProt),
    .AxiReadDataValid_ValOut     (rValid),
    .AxiReadDataReady_RdyIn      (rReady),
    .AxiReadDataResponse_DatOut  (rResp),
    .AxiReadDataData_DatOut      (rData)
  );

  int passCnt = 0;
  int totalCnt = 0;

  typedef struct {
    logic        lvl;
    logic [31:0] sec;
    logic [31:0] ns;
  } edgeExp_t;

  edgeExp_t    edgeQ[$];
  logic [31:0] readQ[$];
  logic [1:0]  bQ[$];
  logic [31:0] smpSec, smpNs;

  // ClockTime sample that the DUT saw on the most recent rising edge.
  always @(posedge clk) begin
    smpSec <= timeSec;
    smpNs  <= timeNs;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    totalCnt++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic edgeExp_t mkEdge(input logic lvl, input logic [31:0] sec, input logic [31:0] ns);
    edgeExp_t e;
    e.lvl = lvl;
    e.sec = sec;
    e.ns  = ns;
    return e;
  endfunction

  // Output-edge monitor: every change of the output must match the next
  // expected edge, including the ClockTime sample that caused it.
  initial begin : edgeMon
    logic     prevEvt;
    edgeExp_t e;
    prevEvt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        prevEvt = evt;
      end else if (evt !== prevEvt) begin
        if (edgeQ.size() == 0) begin
          failNow($sformatf("unexpectedEdge lvl=%0b sec=%0d ns=%0d", evt, smpSec, smpNs));
        end else begin
          e = edgeQ.pop_front();
          check("edgeLevel", {31'd0, evt}, {31'd0, e.lvl});
          check("edgeSecond", smpSec, e.sec);
          check("edgeNs", smpNs, e.ns);
        end
        prevEvt = evt;
      end
    end
  end

  initial begin : readMon
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rstN && rValid && rReady) begin
        if (readQ.size() == 0) begin
          failNow("unexpectedRvalid");
        end else begin
          exp = readQ.pop_front();
          check("rdata", rData, exp);
          check("rresp", {30'd0, rResp}, 32'd0);
        end
      end
    end
  end

  initial begin : respMon
    logic [1:0] exp;
    forever begin
      @(negedge clk);
      if (rstN && bValid && bReady) begin
        if (bQ.size() == 0) begin
          failNow("unexpectedBvalid");
        end else begin
          exp = bQ.pop_front();
          check("bresp", {30'd0, bResp}, {30'd0, exp});
        end
      end
    end
  end

  // One clock of stimulus; ClockTime advances by timeStep ns per cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (timeStep != 0) begin
      if (timeNs + timeStep >= NS1E9) begin
        timeNs  = timeNs + timeStep - NS1E9;
        timeSec = timeSec + 1;
      end else begin
        timeNs = timeNs + timeStep;
      end
    end
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tickUntil(input logic [31:0] sec, input logic [31:0] ns);
    bit reached;
    reached = 0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      if (timeSec == sec && timeNs >= ns) reached = 1;
      else tick();
    end
    if (!reached) failNow("tickUntilTimeout");
  endtask

  task automatic waitDrain(input bit forB);
    for (int i = 0; i < 50; i++) begin
      if ((forB ? bQ.size() : readQ.size()) == 0) break;
      tick();
    end
    check(forB ? "writeRespDrained" : "readDataDrained",
          32'(forB ? bQ.size() : readQ.size()), 32'd0);
  endtask

  task automatic axiWrite(input logic [15:0] addr, input logic [31:0] data,
                          input int awLead, input bit waitB);
    bit done;
    bQ.push_back(2'b00);
    awAddr  = addr;
    wData   = data;
    awValid = 1'b1;
    for (int i = 0; i < awLead; i++) begin
      @(negedge clk);
      check("awReadyWithoutW", {31'd0, awReady}, 32'd0);
      check("wReadyWithoutW", {31'd0, wReady}, 32'd0);
      tick();
    end
    wValid = 1'b1;
    done   = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (awReady && wReady) done = 1;
      tick();
    end
    awValid = 1'b0;
    wValid  = 1'b0;
    if (!done) failNow("writeHandshakeTimeout");
    if (waitB) waitDrain(1'b1);
  endtask

  task automatic axiRead(input logic [15:0] addr, input logic [31:0] exp);
    bit done;
    readQ.push_back(exp);
    arAddr  = addr;
    arValid = 1'b1;
    done    = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (arReady) done = 1;
      tick();
    end
    arValid = 1'b0;
    if (!done) failNow("readHandshakeTimeout");
    waitDrain(1'b0);
  endtask

  task automatic setTime(input logic [31:0] sec, input logic [31:0] ns, input logic [31:0] step);
    timeSec  = sec;
    timeNs   = ns;
    timeStep = step;
    timeVal  = 1'b1;
    timeJump = 1'b0;
  endtask

  initial begin
    rstN = 1'b0;
    setTime(0, 0, 0);
    timeVal = 1'b0;
    awAddr = '0; arAddr = '0; wData = '0; awProt = '0; arProt = '0; wStrb = 4'hF;

    // Reset with random bus activity: nothing may respond.
    for (int i = 0; i < 5; i++) begin
      awValid = 1'($urandom); wValid = 1'($urandom); arValid = 1'($urandom);
      bReady  = 1'($urandom); rReady = 1'($urandom);
      awAddr  = 16'($urandom); arAddr = 16'($urandom); wData = $urandom;
      @(negedge clk);
      check("rstAwReady", {31'd0, awReady}, 32'd0);
      check("rstArReady", {31'd0, arReady}, 32'd0);
      tick();
    end
    @(negedge clk);
    check("rstWReady", {31'd0, wReady}, 32'd0);
    check("rstBValid", {31'd0, bValid}, 32'd0);
    check("rstRValid", {31'd0, rValid}, 32'd0);
    check("rstBResp", {30'd0, bResp}, 32'd0);
    check("rstRResp", {30'd0, rResp}, 32'd0);
    check("rstRData", rData, 32'd0);
    check("rstEvt", {31'd0, evt}, 32'd0);
    awValid = 0; wValid = 0; arValid = 0; bReady = 1; rReady = 1;
    tick();
    rstN = 1'b1;
    tick();

    // Register map after reset.
    axiRead(16'h000C, 32'h0001_0000);
    axiRead(16'h0000, 32'd0);
    axiRead(16'h0004, 32'd0);
    axiRead(16'h0008, 32'd0);
    axiRead(16'h0010, 32'd0);

    // HalfPeriod 250 ms: two full cycles per second.
    setTime(0, 0, 32'd10_000_000);
    axiWrite(16'h0010, 32'hDEAD_BEEF, 0, 1);
    axiWrite(16'h0008, 32'd250_000_000, 0, 1);
    for (int s = 1; s <= 2; s++) begin
      edgeQ.push_back(mkEdge(1'b1, 32'(s), 32'd0));
      edgeQ.push_back(mkEdge(1'b0, 32'(s), 32'd250_000_000));
      edgeQ.push_back(mkEdge(1'b1, 32'(s), 32'd500_000_000));
      edgeQ.push_back(mkEdge(1'b0, 32'(s), 32'd750_000_000));
    end
    axiWrite(16'h0000, 32'd1, 0, 1);
    axiRead(16'h0010, 32'd0);
    tickUntil(2, 32'd800_000_000);
    axiWrite(16'h0000, 32'd0, 0, 1);
    check("edges250Seen", 32'(edgeQ.size()), 32'd0);
    axiRead(16'h0004, 32'd0);

    // HalfPeriod 300 ms: truncated last cycle, forced active at the wrap.
    setTime(5, 0, 32'd10_000_000);
    axiWrite(16'h0008, 32'd300_000_000, 0, 1);
    for (int s = 6; s <= 7; s++) begin
      edgeQ.push_back(mkEdge(1'b1, 32'(s), 32'd0));
      edgeQ.push_back(mkEdge(1'b0, 32'(s), 32'd300_000_000));
      edgeQ.push_back(mkEdge(1'b1, 32'(s), 32'd600_000_000));
      edgeQ.push_back(mkEdge(1'b0, 32'(s), 32'd900_000_000));
    end
    axiWrite(16'h0000, 32'd1, 0, 1);
    tickUntil(7, 32'd950_000_000);
    axiWrite(16'h0000, 32'd0, 0, 1);
    check("edges300Seen", 32'(edgeQ.size()), 32'd0);
    axiRead(16'h0004, 32'd0);

    // Half-period range limits with time frozen.
    setTime(40, 0, 32'd0);
    axiWrite(16'h0008, 32'd30, 0, 1);
    axiWrite(16'h0000, 32'd1, 0, 1);
    tickN(2);
    axiRead(16'h0000, 32'd0);
    axiRead(16'h0004, 32'd1);
    axiWrite(16'h0004, 32'd1, 0, 1);
    axiRead(16'h0004, 32'd0);
    axiWrite(16'h0008, 32'd500_000_001, 0, 1);
    axiWrite(16'h0000, 32'd1, 0, 1);
    tickN(2);
    axiRead(16'h0004, 32'd1);
    axiWrite(16'h0004, 32'd1, 0, 1);
    axiWrite(16'h0008, 32'd40, 0, 1);
    axiWrite(16'h0000, 32'd1, 0, 1);
    tickN(3);
    axiRead(16'h0004, 32'd0);
    axiRead(16'h0000, 32'd1);
    axiWrite(16'h0000, 32'd0, 0, 1);

    // Time jump while running.
    setTime(20, 0, 32'd10_000_000);
    axiWrite(16'h0008, 32'd250_000_000, 0, 1);
    edgeQ.push_back(mkEdge(1'b1, 32'd21, 32'd0));
    edgeQ.push_back(mkEdge(1'b0, 32'd21, 32'd250_000_000));
    edgeQ.push_back(mkEdge(1'b1, 32'd21, 32'd500_000_000));
    edgeQ.push_back(mkEdge(1'b0, 32'd21, 32'd600_000_000));
    edgeQ.push_back(mkEdge(1'b1, 32'd22, 32'd0));
    edgeQ.push_back(mkEdge(1'b0, 32'd22, 32'd250_000_000));
    axiWrite(16'h0000, 32'd1, 0, 1);
    tickUntil(21, 32'd600_000_000);
    timeJump = 1'b1;
    tick();
    timeJump = 1'b0;
    tickUntil(22, 32'd300_000_000);
    axiWrite(16'h0000, 32'd0, 0, 1);
    check("edgesJumpSeen", 32'(edgeQ.size()), 32'd0);
    axiRead(16'h0004, 32'd1);
    axiWrite(16'h0004, 32'd1, 0, 1);
    axiRead(16'h0004, 32'd0);

    // Write handshake: AW leads W, then a back-pressured response.
    setTime(50, 0, 32'd0);
    axiWrite(16'h0008, 32'd123, 5, 1);
    axiRead(16'h0008, 32'd123);
    bReady = 1'b0;
    axiWrite(16'h0008, 32'd777, 0, 0);
    awAddr = 16'h0008; wData = 32'd999; awValid = 1'b1; wValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bValidHeld", {31'd0, bValid}, 32'd1);
      check("noSecondWrite", {31'd0, awReady}, 32'd0);
      tick();
    end
    axiRead(16'h0008, 32'd777);
    bReady = 1'b1;
    axiWrite(16'h0008, 32'd999, 0, 1);
    axiRead(16'h0008, 32'd999);

    // Asynchronous reset in the middle of a high phase.
    setTime(30, 0, 32'd10_000_000);
    axiWrite(16'h0008, 32'd250_000_000, 0, 1);
    edgeQ.push_back(mkEdge(1'b1, 32'd31, 32'd0));
    axiWrite(16'h0000, 32'd1, 0, 1);
    tickUntil(31, 32'd100_000_000);
    #5;
    rstN = 1'b0;
    #1;
    check("asyncRstEvt", {31'd0, evt}, 32'd0);
    tickN(3);
    check("edgesRstSeen", 32'(edgeQ.size()), 32'd0);
    rstN = 1'b1;
    tick();
    axiRead(16'h0000, 32'd0);
    axiRead(16'h0008, 32'd0);
    tickN(5);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
